// File: rtl/pspin_hostmem_ar_splitter_pkg.sv
// Shared types and encodings for the host-memory AR burst splitter.
package pspin_hostmem_ar_splitter_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned BOUNDARY_DEFAULT  = 4096;
  localparam int unsigned MAX_BEATS_DEFAULT = 64;
  localparam int unsigned BEAT_CNT_W        = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN
  } state_e;

  // AR sideband forwarded untouched on every sub-burst
  typedef struct packed {
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
  } ar_side_t;

endpackage

// File: rtl/pspin_hostmem_ar_splitter_burst_calc.sv
// Sub-burst sizing: beats until the page end, capped by remaining beats and MAX_BEATS.
module pspin_hostmem_ar_splitter_burst_calc
  import pspin_hostmem_ar_splitter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned MAX_BEATS  = MAX_BEATS_DEFAULT,
  parameter int unsigned BOUNDARY   = BOUNDARY_DEFAULT
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [2:0]            size_i,
  input  logic [BEAT_CNT_W-1:0] rem_beats_i,
  output logic [BEAT_CNT_W-1:0] sub_beats_o,
  output logic [ADDR_WIDTH-1:0] next_addr_o
);

  localparam int unsigned PAGE_BITS = $clog2(BOUNDARY);
  localparam int unsigned CW        = (PAGE_BITS + 1 > 10) ? PAGE_BITS + 1 : 10;

  logic [CW-1:0] to_page;
  logic [CW-1:0] limit;

  always_comb begin
    to_page = (CW'(BOUNDARY) - CW'(addr_i[PAGE_BITS-1:0])) >> size_i;
    limit   = CW'(rem_beats_i);
    if (to_page < limit) limit = to_page;
    if (CW'(MAX_BEATS) < limit) limit = CW'(MAX_BEATS);
    sub_beats_o = BEAT_CNT_W'(limit);
    next_addr_o = addr_i + (ADDR_WIDTH'(sub_beats_o) << size_i);
  end

endmodule

// File: rtl/pspin_hostmem_ar_splitter.sv
// AXI4 read-burst splitter: page/length-bounded sub-bursts downstream, one
// reassembled burst with a single rlast upstream.
module pspin_hostmem_ar_splitter
  import pspin_hostmem_ar_splitter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 64,
  parameter int unsigned DATA_WIDTH   = 512,
  parameter int unsigned ID_WIDTH     = 8,
  parameter int unsigned ARUSER_WIDTH = 1,
  parameter int unsigned RUSER_WIDTH  = 1,
  parameter int unsigned MAX_BEATS    = MAX_BEATS_DEFAULT,
  parameter int unsigned BOUNDARY     = BOUNDARY_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic [3:0]              s_axi_arregion,
  input  logic [ARUSER_WIDTH-1:0] s_axi_aruser,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic [RUSER_WIDTH-1:0]  s_axi_ruser,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic [3:0]              m_axi_arregion,
  output logic [ARUSER_WIDTH-1:0] m_axi_aruser,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic [RUSER_WIDTH-1:0]  m_axi_ruser,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  state_e state_q, state_d;

  logic                    s_arready_q, s_arready_d;
  logic                    m_arvalid_q, m_arvalid_d;
  logic [ID_WIDTH-1:0]     m_arid_q, m_arid_d;
  logic [ADDR_WIDTH-1:0]   m_araddr_q, m_araddr_d;
  logic [7:0]              m_arlen_q, m_arlen_d;
  logic [2:0]              m_arsize_q, m_arsize_d;
  logic [1:0]              m_arburst_q, m_arburst_d;
  ar_side_t                m_side_q, m_side_d;
  logic [ARUSER_WIDTH-1:0] m_aruser_q, m_aruser_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [BEAT_CNT_W-1:0]   rem_q, rem_d;

  logic [ADDR_WIDTH-1:0]   calc_addr;
  logic [2:0]              calc_size;
  logic [BEAT_CNT_W-1:0]   calc_rem;
  logic [BEAT_CNT_W-1:0]   sub_beats;
  logic [ADDR_WIDTH-1:0]   next_addr;
  logic                    in_drain;

  // Calculator sees the incoming request in IDLE, the running sub-burst state otherwise
  always_comb begin
    if (state_q == ST_IDLE) begin
      calc_addr = s_axi_araddr &
                  ~((ADDR_WIDTH'(1) << s_axi_arsize) - ADDR_WIDTH'(1));
      calc_size = s_axi_arsize;
      calc_rem  = BEAT_CNT_W'(s_axi_arlen) + BEAT_CNT_W'(1);
    end else begin
      calc_addr = addr_q;
      calc_size = m_arsize_q;
      calc_rem  = rem_q;
    end
  end

  pspin_hostmem_ar_splitter_burst_calc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MAX_BEATS  (MAX_BEATS),
    .BOUNDARY   (BOUNDARY)
  ) u_burst_calc (
    .addr_i      (calc_addr),
    .size_i      (calc_size),
    .rem_beats_i (calc_rem),
    .sub_beats_o (sub_beats),
    .next_addr_o (next_addr)
  );

  always_comb begin
    state_d     = state_q;
    m_arvalid_d = m_arvalid_q;
    m_arid_d    = m_arid_q;
    m_araddr_d  = m_araddr_q;
    m_arlen_d   = m_arlen_q;
    m_arsize_d  = m_arsize_q;
    m_arburst_d = m_arburst_q;
    m_side_d    = m_side_q;
    m_aruser_d  = m_aruser_q;
    addr_d      = addr_q;
    rem_d       = rem_q;

    case (state_q)
      ST_IDLE: begin
        if (s_axi_arvalid && s_arready_q) begin
          m_arid_d    = s_axi_arid;
          m_arsize_d  = s_axi_arsize;
          m_arburst_d = s_axi_arburst;
          m_side_d    = '{lock: s_axi_arlock, cache: s_axi_arcache, prot: s_axi_arprot,
                          qos: s_axi_arqos, region: s_axi_arregion};
          m_aruser_d  = s_axi_aruser;
          if (s_axi_arburst == BURST_INCR) begin
            m_araddr_d = calc_addr;
            m_arlen_d  = 8'(sub_beats - BEAT_CNT_W'(1));
            addr_d     = next_addr;
            rem_d      = calc_rem - sub_beats;
          end else begin
            // FIXED/WRAP go out whole; splitting them would change their semantics
            m_araddr_d = s_axi_araddr;
            m_arlen_d  = s_axi_arlen;
            addr_d     = s_axi_araddr;
            rem_d      = '0;
          end
          m_arvalid_d = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (m_axi_arready) begin
          m_arvalid_d = 1'b0;
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (m_axi_rvalid && s_axi_rready && m_axi_rlast) begin
          if (rem_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            m_araddr_d  = addr_q;
            m_arlen_d   = 8'(sub_beats - BEAT_CNT_W'(1));
            addr_d      = next_addr;
            rem_d       = rem_q - sub_beats;
            m_arvalid_d = 1'b1;
            state_d     = ST_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    s_arready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      s_arready_q <= 1'b0;
      m_arvalid_q <= 1'b0;
      m_arid_q    <= '0;
      m_araddr_q  <= '0;
      m_arlen_q   <= '0;
      m_arsize_q  <= '0;
      m_arburst_q <= '0;
      m_side_q    <= '0;
      m_aruser_q  <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
    end else begin
      state_q     <= state_d;
      s_arready_q <= s_arready_d;
      m_arvalid_q <= m_arvalid_d;
      m_arid_q    <= m_arid_d;
      m_araddr_q  <= m_araddr_d;
      m_arlen_q   <= m_arlen_d;
      m_arsize_q  <= m_arsize_d;
      m_arburst_q <= m_arburst_d;
      m_side_q    <= m_side_d;
      m_aruser_q  <= m_aruser_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
    end
  end

  assign s_axi_arready  = s_arready_q;
  assign m_axi_arvalid  = m_arvalid_q;
  assign m_axi_arid     = m_arid_q;
  assign m_axi_araddr   = m_araddr_q;
  assign m_axi_arlen    = m_arlen_q;
  assign m_axi_arsize   = m_arsize_q;
  assign m_axi_arburst  = m_arburst_q;
  assign m_axi_arlock   = m_side_q.lock;
  assign m_axi_arcache  = m_side_q.cache;
  assign m_axi_arprot   = m_side_q.prot;
  assign m_axi_arqos    = m_side_q.qos;
  assign m_axi_arregion = m_side_q.region;
  assign m_axi_aruser   = m_aruser_q;

  // Zero-latency R path; rlast only surfaces on the parent's final sub-burst
  assign in_drain     = (state_q == ST_DRAIN);
  assign s_axi_rvalid = m_axi_rvalid && in_drain;
  assign m_axi_rready = s_axi_rready && in_drain;
  assign s_axi_rlast  = m_axi_rlast && in_drain && (rem_q == '0);
  assign s_axi_rid    = m_axi_rid;
  assign s_axi_rdata  = m_axi_rdata;
  assign s_axi_rresp  = m_axi_rresp;
  assign s_axi_ruser  = m_axi_ruser;

endmodule

// File: tb/tb_pspin_hostmem_ar_splitter.sv
// Directed bench for the AR splitter with a single-transaction downstream model.
module tb_pspin_hostmem_ar_splitter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   s_axi_arid = '0;
  logic [63:0]  s_axi_araddr = '0;
  logic [7:0]   s_axi_arlen = '0;
  logic [2:0]   s_axi_arsize = '0;
  logic [1:0]   s_axi_arburst = '0;
  logic         s_axi_arlock = 1'b0;
  logic [3:0]   s_axi_arcache = '0;
  logic [2:0]   s_axi_arprot = '0;
  logic [3:0]   s_axi_arqos = '0;
  logic [3:0]   s_axi_arregion = '0;
  logic [0:0]   s_axi_aruser = '0;
  logic         s_axi_arvalid = 1'b0;
  logic         s_axi_arready;
  logic [7:0]   s_axi_rid;
  logic [511:0] s_axi_rdata;
  logic [1:0]   s_axi_rresp;
  logic [0:0]   s_axi_ruser;
  logic         s_axi_rlast;
  logic         s_axi_rvalid;
  logic         s_axi_rready = 1'b0;
  logic [7:0]   m_axi_arid;
  logic [63:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic [2:0]   m_axi_arsize;
  logic [1:0]   m_axi_arburst;
  logic         m_axi_arlock;
  logic [3:0]   m_axi_arcache;
  logic [2:0]   m_axi_arprot;
  logic [3:0]   m_axi_arqos;
  logic [3:0]   m_axi_arregion;
  logic [0:0]   m_axi_aruser;
  logic         m_axi_arvalid;
  logic         m_axi_arready = 1'b0;
  logic [7:0]   m_axi_rid = '0;
  logic [511:0] m_axi_rdata = '0;
  logic [1:0]   m_axi_rresp = '0;
  logic [0:0]   m_axi_ruser = '0;
  logic         m_axi_rlast = 1'b0;
  logic         m_axi_rvalid = 1'b0;
  logic         m_axi_rready;

  pspin_hostmem_ar_splitter dut (
    .clk(clk), .rst(rst),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
    .s_axi_arregion(s_axi_arregion), .s_axi_aruser(s_axi_aruser), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_ruser(s_axi_ruser), .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arregion(m_axi_arregion), .m_axi_aruser(m_axi_aruser), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_ruser(m_axi_ruser), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Control flags written only by the main sequence
  logic bp = 1'b0;
  logic slv_first = 1'b0;
  logic clr_req = 1'b0;

  // Environment state written only by the environment process
  int          ar_cnt = 0;
  logic [63:0] ar_addr_log [8];
  logic [7:0]  ar_len_log [8];
  logic [1:0]  ar_burst_log [8];
  logic [2:0]  ar_size_log [8];
  logic [3:0]  ar_cache_log [8];
  int          mon_beats = 0;
  int          rlast_cnt = 0;
  int          last_idx = -1;
  int          data_err = 0;
  logic [1:0]  resp_log [8];
  logic [7:0]  last_rid = '0;
  int          gbeat = 0;
  logic        have = 1'b0;
  int          sbeat = 0;
  logic [7:0]  cur_len = '0;
  logic [7:0]  cur_id = '0;

  // Downstream single-transaction slave plus upstream R monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        have = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b0;
        m_axi_rlast = 1'b0;
      end else begin
        m_axi_arready = have ? 1'b0 : (bp ? 1'($urandom_range(0, 1)) : 1'b1);
        if (have) begin
          m_axi_rvalid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
          m_axi_rdata  = 512'(gbeat);
          m_axi_rlast  = (8'(sbeat) == cur_len);
          m_axi_rid    = cur_id;
          m_axi_rresp  = (slv_first && ar_cnt == 1) ? 2'b10 : 2'b00;
        end else begin
          m_axi_rvalid = 1'b0;
          m_axi_rlast  = 1'b0;
        end
      end
      s_axi_rready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (clr_req) begin
        ar_cnt = 0; mon_beats = 0; rlast_cnt = 0; last_idx = -1;
        data_err = 0; gbeat = 0;
      end else if (!rst) begin
        if (s_axi_rvalid && s_axi_rready) begin
          if (s_axi_rdata[31:0] != 32'(mon_beats)) data_err++;
          if (mon_beats < 8) resp_log[mon_beats] = s_axi_rresp;
          last_rid = s_axi_rid;
          if (s_axi_rlast) begin
            rlast_cnt++;
            last_idx = mon_beats;
          end
          mon_beats++;
        end
        if (m_axi_rvalid && m_axi_rready) begin
          gbeat++;
          sbeat++;
          if (m_axi_rlast) have = 1'b0;
        end
        if (m_axi_arvalid && m_axi_arready) begin
          if (ar_cnt < 8) begin
            ar_addr_log[ar_cnt]  = m_axi_araddr;
            ar_len_log[ar_cnt]   = m_axi_arlen;
            ar_burst_log[ar_cnt] = m_axi_arburst;
            ar_size_log[ar_cnt]  = m_axi_arsize;
            ar_cache_log[ar_cnt] = m_axi_arcache;
          end
          ar_cnt++;
          have = 1'b1;
          sbeat = 0;
          cur_len = m_axi_arlen;
          cur_id = m_axi_arid;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_env();
    clr_req = 1'b1;
    @(negedge clk);
    #2 clr_req = 1'b0;
  endtask

  task automatic issue_ar(input logic [63:0] addr, input logic [2:0] size,
                          input logic [7:0] len, input logic [1:0] burst, input logic [7:0] id);
    logic ok = 1'b0;
    s_axi_araddr = addr; s_axi_arsize = size; s_axi_arlen = len;
    s_axi_arburst = burst; s_axi_arid = id; s_axi_arcache = 4'h3;
    s_axi_arvalid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      #1;
      if (s_axi_arready) ok = 1'b1;
      @(negedge clk);
    end
    s_axi_arvalid = 1'b0;
    check("ar_accept", 64'(ok), 64'd1);
    #1;
    check("arready_busy", 64'(s_axi_arready), 64'd0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 4000 && rlast_cnt == 0; i++) @(negedge clk);
    repeat (6) @(negedge clk);
    #2;
    check("rlast_cnt", 64'(rlast_cnt), 64'd1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check("rst_arready", 64'(s_axi_arready), 64'd0);
    check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    check("rst_araddr", m_axi_araddr, 64'd0);
    check("rst_arlen", 64'(m_axi_arlen), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    #2;
    check("arready_after_rst", 64'(s_axi_arready), 64'd1);

    // 1: aligned, single sub-burst
    clear_env();
    issue_ar(64'h1000, 3'd6, 8'd15, 2'b01, 8'h5A);
    wait_done();
    check("t1_ar_cnt", 64'(ar_cnt), 64'd1);
    check("t1_addr", ar_addr_log[0], 64'h1000);
    check("t1_len", 64'(ar_len_log[0]), 64'd15);
    check("t1_cache", 64'(ar_cache_log[0]), 64'h3);
    check("t1_beats", 64'(mon_beats), 64'd16);
    check("t1_last_idx", 64'(last_idx), 64'd15);
    check("t1_rid", 64'(last_rid), 64'h5A);
    check("t1_data", 64'(data_err), 64'd0);

    // 2: crosses 4 KiB page after one beat
    clear_env();
    issue_ar(64'h0FC0, 3'd6, 8'd3, 2'b01, 8'h11);
    wait_done();
    check("t2_ar_cnt", 64'(ar_cnt), 64'd2);
    check("t2_addr0", ar_addr_log[0], 64'h0FC0);
    check("t2_len0", 64'(ar_len_log[0]), 64'd0);
    check("t2_addr1", ar_addr_log[1], 64'h1000);
    check("t2_len1", 64'(ar_len_log[1]), 64'd2);
    check("t2_beats", 64'(mon_beats), 64'd4);
    check("t2_last_idx", 64'(last_idx), 64'd3);

    // 3: 256 beats capped at 64 per sub-burst
    clear_env();
    issue_ar(64'h2000, 3'd6, 8'd255, 2'b01, 8'h22);
    wait_done();
    check("t3_ar_cnt", 64'(ar_cnt), 64'd4);
    check("t3_addr0", ar_addr_log[0], 64'h2000);
    check("t3_addr1", ar_addr_log[1], 64'h3000);
    check("t3_addr2", ar_addr_log[2], 64'h4000);
    check("t3_addr3", ar_addr_log[3], 64'h5000);
    check("t3_len0", 64'(ar_len_log[0]), 64'd63);
    check("t3_len3", 64'(ar_len_log[3]), 64'd63);
    check("t3_size", 64'(ar_size_log[2]), 64'd6);
    check("t3_beats", 64'(mon_beats), 64'd256);
    check("t3_last_idx", 64'(last_idx), 64'd255);
    check("t3_data", 64'(data_err), 64'd0);

    // 4: FIXED burst forwarded untouched even though it straddles a page
    clear_env();
    issue_ar(64'h0FFC, 3'd2, 8'd3, 2'b00, 8'h33);
    wait_done();
    check("t4_ar_cnt", 64'(ar_cnt), 64'd1);
    check("t4_addr", ar_addr_log[0], 64'h0FFC);
    check("t4_len", 64'(ar_len_log[0]), 64'd3);
    check("t4_burst", 64'(ar_burst_log[0]), 64'd0);
    check("t4_beats", 64'(mon_beats), 64'd4);
    check("t4_last_idx", 64'(last_idx), 64'd3);

    // 5: SLVERR on first sub-burst only
    clear_env();
    slv_first = 1'b1;
    issue_ar(64'h0FC0, 3'd6, 8'd3, 2'b01, 8'h44);
    wait_done();
    slv_first = 1'b0;
    check("t5_ar_cnt", 64'(ar_cnt), 64'd2);
    check("t5_resp0", 64'(resp_log[0]), 64'd2);
    check("t5_resp1", 64'(resp_log[1]), 64'd0);
    check("t5_resp3", 64'(resp_log[3]), 64'd0);
    check("t5_beats", 64'(mon_beats), 64'd4);

    // 6: backpressure, reset while draining, then a clean burst
    clear_env();
    bp = 1'b1;
    issue_ar(64'h0FC0, 3'd6, 8'd7, 2'b01, 8'h55);
    for (int i = 0; i < 1000 && mon_beats < 3; i++) @(negedge clk);
    check("t6_progress", 64'(mon_beats >= 3), 64'd1);
    check("t6_no_early_rlast", 64'(rlast_cnt), 64'd0);
    #3 rst = 1'b1;
    #1;
    check("t6_rst_arready", 64'(s_axi_arready), 64'd0);
    check("t6_rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    check("t6_rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    check("t6_rst_rready", 64'(m_axi_rready), 64'd0);
    check("t6_rst_araddr", m_axi_araddr, 64'd0);
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    clear_env();
    issue_ar(64'h0FC0, 3'd6, 8'd3, 2'b01, 8'h66);
    wait_done();
    bp = 1'b0;
    check("t6_ar_cnt", 64'(ar_cnt), 64'd2);
    check("t6_addr1", ar_addr_log[1], 64'h1000);
    check("t6_len1", 64'(ar_len_log[1]), 64'd2);
    check("t6_beats", 64'(mon_beats), 64'd4);
    check("t6_last_idx", 64'(last_idx), 64'd3);
    check("t6_data", 64'(data_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
